// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the text/tile display stage.
//
// Divides clk into a one-cycle pixel enable (p_tick) and runs horizontal and
// vertical counters that advance only on that enable. Sync outputs are
// registered from the next-state counts, so they switch on the same edge as
// the coordinates.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   p_tick    out  pixel enable, high one clk in every TICK_DIV
//   pixel_x   out  horizontal count, 0..H_TOTAL-1 (straight from register)
//   pixel_y   out  vertical count, 0..V_TOTAL-1 (straight from register)
//   video_on  out  high inside the visible H_DISPLAY x V_DISPLAY area
//   hsync     out  horizontal sync, asserted level SYNC_ACTIVE
//   vsync     out  vertical sync, asserted level SYNC_ACTIVE
//   frame_end out  high on the tick that wraps the raster back to (0,0)
module vga_sync_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int TICK_DIV    = 2,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_end
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    // A one-bit divider is kept even for TICK_DIV = 1; it simply stays at 0.
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_end_q, frame_end_d;

    // Next-state logic for divider, raster counters and registered outputs.
    always_comb begin
        div_d       = div_q;
        p_tick_d    = 1'b0;
        h_d         = h_q;
        v_d         = v_q;
        hsync_d     = ~SYNC_ON;
        vsync_d     = ~SYNC_ON;
        frame_end_d = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // The tick is a registered compare of the current divider value, so
        // it lands TICK_DIV edges after reset release.
        p_tick_d = (div_q == DIV_LAST);

        if (p_tick_q) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                if (v_q == V_LAST) begin
                    v_d = 10'd0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end

        // Syncs decode the next-state counts so they flip with the counters.
        if ((h_d >= HS_START) && (h_d <= HS_END)) begin
            hsync_d = SYNC_ON;
        end else begin
            hsync_d = ~SYNC_ON;
        end

        if ((v_d >= VS_START) && (v_d <= VS_END)) begin
            vsync_d = SYNC_ON;
        end else begin
            vsync_d = ~SYNC_ON;
        end

        // Flag the cycle that will carry the wrapping tick at (H_LAST,V_LAST).
        frame_end_d = p_tick_d && (h_d == H_LAST) && (v_d == V_LAST);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            p_tick_q    <= 1'b0;
            h_q         <= 10'd0;
            v_q         <= 10'd0;
            hsync_q     <= ~SYNC_ON;
            vsync_q     <= ~SYNC_ON;
            frame_end_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            p_tick_q    <= p_tick_d;
            h_q         <= h_d;
            v_q         <= v_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign p_tick    = p_tick_q;
    assign pixel_x   = h_q;
    assign pixel_y   = v_q;
    assign video_on  = (h_q < H_VIS) && (v_q < V_VIS);
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign frame_end = frame_end_q;

endmodule
